// File: rtl/pot_hist_reg.sv
// Power-sample history register for the P&O datapath: keeps current/previous
// samples, a hysteresis-qualified signed delta and a DEPTH-sample moving average.
module pot_hist_reg #(
    parameter int unsigned W     = 12,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LOG2D = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           p_valid,
    input  logic [W-1:0]   p,
    input  logic [W-1:0]   hyst,
    output logic [W-1:0]   pot_act,
    output logic [W-1:0]   pot_ant,
    output logic [W:0]     delta,
    output logic           inc,
    output logic           dec,
    output logic           eq,
    output logic           cmp_valid,
    output logic [W-1:0]   pot_avg,
    output logic           hist_full,
    output logic           out_valid
);

    localparam logic [LOG2D:0] CNT_MAX = (LOG2D+1)'(DEPTH);
    localparam logic [LOG2D:0] CNT_TWO = (LOG2D+1)'(2);

    logic [W-1:0]       r_hist [DEPTH];
    logic [W+LOG2D-1:0] r_sum;
    logic [LOG2D:0]     r_cnt;
    logic [W-1:0]       r_act;
    logic [W-1:0]       r_ant;
    logic [W:0]         r_delta;
    logic               r_inc;
    logic               r_dec;
    logic               r_eq;
    logic               r_cmp_valid;
    logic [W-1:0]       r_avg;
    logic               r_full;
    logic               r_out_valid;

    logic [W:0]          w_delta;
    logic signed [W+1:0] w_dx;
    logic signed [W+1:0] w_hx;
    logic                w_inc;
    logic                w_dec;
    logic [W+LOG2D-1:0]  w_sum_next;
    logic [LOG2D:0]      w_cnt_next;

    always_comb begin
        w_delta    = {1'b0, p} - {1'b0, r_act};
        // one extra bit so that -hyst is representable for any W-bit hyst
        w_dx       = signed'({w_delta[W], w_delta});
        w_hx       = signed'({2'b00, hyst});
        w_inc      = (w_dx > w_hx);
        w_dec      = (w_dx < -w_hx);
        w_sum_next = r_sum + {{LOG2D{1'b0}}, p} - {{LOG2D{1'b0}}, r_hist[DEPTH-1]};
        w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_hist[i] <= '0;
            end
            r_sum       <= '0;
            r_cnt       <= '0;
            r_act       <= '0;
            r_ant       <= '0;
            r_delta     <= '0;
            r_inc       <= 1'b0;
            r_dec       <= 1'b0;
            r_eq        <= 1'b1;
            r_cmp_valid <= 1'b0;
            r_avg       <= '0;
            r_full      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= p_valid;
            if (p_valid) begin
                r_hist[0] <= p;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    r_hist[i] <= r_hist[i-1];
                end
                r_sum       <= w_sum_next;
                r_cnt       <= w_cnt_next;
                r_ant       <= r_act;
                r_act       <= p;
                r_delta     <= w_delta;
                r_inc       <= w_inc;
                r_dec       <= w_dec;
                r_eq        <= ~(w_inc | w_dec);
                r_cmp_valid <= (w_cnt_next >= CNT_TWO);
                r_avg       <= w_sum_next[W+LOG2D-1:LOG2D];
                r_full      <= (w_cnt_next == CNT_MAX);
            end
        end
    end

    assign pot_act   = r_act;
    assign pot_ant   = r_ant;
    assign delta     = r_delta;
    assign inc       = r_inc;
    assign dec       = r_dec;
    assign eq        = r_eq;
    assign cmp_valid = r_cmp_valid;
    assign pot_avg   = r_avg;
    assign hist_full = r_full;
    assign out_valid = r_out_valid;

endmodule

// File: doc/pot_hist_reg.md
# pot_hist_reg

Parametrised power-sample history register for the MPPT perturb-and-observe datapath. It sits between the power multiplier and the P&O decision FSM. On each sample strobe it captures the new power value, keeps the previous one, and computes a signed delta with hysteresis-qualified increase/decrease/equal flags. It also maintains a DEPTH-sample moving average, so the controller can decide on filtered or raw power.

## Interface
Parameters:
- W, 12: power sample width (unsigned).
- DEPTH, 4: history length for the moving average; power of two, ≥2.
- LOG2D, 2: log2(DEPTH); must match DEPTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous history flush; same effect as rst.
- p_valid  in  1  single-cycle sample strobe.
- p  in  W  new power sample, qualified by p_valid.
- hyst  in  W  unsigned hysteresis threshold, sampled with p_valid.
- pot_act  out  W  most recent accepted sample.
- pot_ant  out  W  sample accepted before pot_act.
- delta  out  W+1  signed pot_act − pot_ant.
- inc / dec / eq  out  1 each  one-hot comparison result.
- cmp_valid  out  1  high once at least two samples have been accepted since reset/clear.
- pot_avg  out  W  floor(sum of last DEPTH samples / DEPTH).
- hist_full  out  1  DEPTH or more samples accepted since reset/clear.
- out_valid  out  1  one-cycle pulse; all outputs updated this cycle.

## Operation
- Storage:
  - Shift register hist[0..DEPTH-1] of W bits; hist[0] is the newest entry.
  - Running sum register of W+LOG2D bits.
  - Saturating sample counter cnt, 0..DEPTH.
- Accept (p_valid=1, rst=0, clr=0):
  - hist shifts: hist[0]←p, hist[i]←hist[i-1].
  - sum←sum + p − hist[DEPTH-1].
  - pot_ant←pot_act; pot_act←p.
  - delta←p − pot_act (old value), sign-extended to W+1 bits.
  - cnt←min(cnt+1, DEPTH).
- Comparison, registered with delta, using the hyst value present at the accept:
  - inc if delta > +hyst.
  - dec if delta < −hyst.
  - eq otherwise. delta = ±hyst gives eq; hyst=0 and delta=0 gives eq.
- cmp_valid = (cnt ≥ 2) after the update.
  - When cmp_valid=0, inc/dec/eq and delta are still computed against pot_ant=0 (raw).
  - The consumer must ignore them while cmp_valid=0.
- pot_avg ← (updated sum) >> LOG2D.
  - Before hist_full, empty slots count as 0. The divisor is always DEPTH, never cnt.
- hist_full = (cnt == DEPTH).
- Idle (p_valid=0): every register holds its value; out_valid=0.
- rst or clr:
  - Every output, hist, sum and cnt go to 0.
  - eq resets to 1 (inc=dec=0), so the flag set stays one-hot.
  - rst/clr beats a simultaneous p_valid; that sample is dropped.
- Sum cannot overflow: its maximum is DEPTH·(2^W−1) in W+LOG2D bits.

## Timing
- Latency: p_valid at edge n → all outputs valid after edge n+1, with out_valid=1 for exactly that cycle.
- Back-to-back p_valid every cycle is supported at full throughput; each strobe produces one out_valid pulse.
- Reset values: pot_act=pot_ant=delta=pot_avg=0, inc=dec=0, eq=1, cmp_valid=hist_full=out_valid=0.
- rst or clr asserted mid-stream takes effect at the next edge. The following p_valid is treated as the first sample: cmp_valid=0, cnt=1.
- p and hyst are only sampled on p_valid cycles; their values on other cycles are don't-care.

## Test plan
All scenarios use W=12, DEPTH=4, LOG2D=2.
1. rst; hyst=5; accept 100,150,140,140.
   - After 1st: act=100, ant=0, cmp_valid=0.
   - After 2nd: delta=+50, inc.
   - After 3rd: delta=−10, dec.
   - After 4th: delta=0, eq, hist_full=1, pot_avg=132.
2. Continue scenario 1 with p=4095 → sum=4525, pot_avg=1131, delta=+3955, inc. Then p=0 → delta=−4095, dec, no wrap.
3. Hysteresis boundary: act=200, hyst=10.
   - p=210 → eq. p=221 → inc.
   - Then hyst=0, p=221 → delta=0, eq.
4. Simultaneous clr and p_valid (p=500) after 3 samples → all outputs 0, eq=1, out_valid=0. Next p=60 → act=60, ant=0, cmp_valid=0, pot_avg=15.
5. p_valid low for 20 cycles between samples → outputs stable, out_valid=0 throughout. Then p_valid on consecutive cycles with 1,2,3,4,5 → five out_valid pulses, final pot_avg=3.
6. rst asserted for one cycle while p_valid=1 mid-stream → reset values next cycle. Average restarts: samples 8,8 give pot_avg=4.
